// File: rtl/spi_slave_apb_sequencer.sv
// Sequences SPI-decoded read/write bursts onto an APB master port.
// Write words are buffered, read words are prefetched, and the address auto-increments.
module spi_slave_apb_sequencer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  sclk,
  input  logic                  sys_rstn,
  input  logic                  cs,
  input  logic                  ctrl_rd_wr,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic                  ctrl_addr_valid,
  input  logic [DATA_WIDTH-1:0] ctrl_data_rx,
  input  logic                  ctrl_data_rx_valid,
  output logic [DATA_WIDTH-1:0] ctrl_data_tx,
  input  logic                  ctrl_data_tx_ready,
  input  logic [15:0]           wrap_length,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [2:0]            err_flags
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned Step = DATA_WIDTH / 8;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           idx_q, idx_d;
  logic                  mode_q, mode_d;
  logic                  active_q, active_d;
  logic                  xfer_valid_q, xfer_valid_d;
  logic                  cs_q;

  logic [DATA_WIDTH-1:0] wmem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rmem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wwptr_q, wwptr_d, wrptr_q, wrptr_d;
  logic [PtrW-1:0]       rwptr_q, rwptr_d, rrptr_q, rrptr_d;
  logic [CntW-1:0]       wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, tx_q, tx_d;
  logic [2:0]            err_q, err_d;

  logic flush, done, xfer_ok, w_pop, w_push, w_full, w_ovf, r_push, r_pop, r_udr;
  logic pending_d, start;
  logic [DATA_WIDTH-1:0] w_head_d, r_head_d;

  always_comb begin
    flush   = cs | ctrl_addr_valid;
    done    = (state_q == StAccess) & pready;
    // Only a transfer that still belongs to the live burst touches the FIFOs or the index.
    xfer_ok = done & xfer_valid_q & ~flush;
    w_pop   = xfer_ok & pwrite_q;
    r_push  = xfer_ok & ~pwrite_q;
    w_full  = (wcnt_q == DepthC);
    w_push  = ctrl_data_rx_valid & ~flush & (~w_full | w_pop);
    w_ovf   = ctrl_data_rx_valid & ~flush & w_full & ~w_pop;
    r_pop   = ctrl_data_tx_ready & ~flush & (rcnt_q != '0);
    r_udr   = ctrl_data_tx_ready & (rcnt_q == '0);

    base_d   = base_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    active_d = active_q;
    if (cs) begin
      active_d = 1'b0;
    end else if (ctrl_addr_valid) begin
      base_d   = ctrl_addr;
      idx_d    = '0;
      mode_d   = ctrl_rd_wr;
      active_d = 1'b1;
    end else if (xfer_ok) begin
      if ((wrap_length != '0) && ((idx_q + 16'd1) == wrap_length)) idx_d = '0;
      else idx_d = idx_q + 16'd1;
    end

    wwptr_d = wwptr_q;
    wrptr_d = wrptr_q;
    wcnt_d  = wcnt_q;
    rwptr_d = rwptr_q;
    rrptr_d = rrptr_q;
    rcnt_d  = rcnt_q;
    if (flush) begin
      wwptr_d = '0;
      wrptr_d = '0;
      wcnt_d  = '0;
      rwptr_d = '0;
      rrptr_d = '0;
      rcnt_d  = '0;
    end else begin
      if (w_push) wwptr_d = wwptr_q + PtrW'(1);
      if (w_pop)  wrptr_d = wrptr_q + PtrW'(1);
      if (w_push && !w_pop) wcnt_d = wcnt_q + CntW'(1);
      if (!w_push && w_pop) wcnt_d = wcnt_q - CntW'(1);
      if (r_push) rwptr_d = rwptr_q + PtrW'(1);
      if (r_pop)  rrptr_d = rrptr_q + PtrW'(1);
      if (r_push && !r_pop) rcnt_d = rcnt_q + CntW'(1);
      if (!r_push && r_pop) rcnt_d = rcnt_q - CntW'(1);
    end

    // Heads as seen after this cycle's updates; bypass the word being written this cycle.
    w_head_d = '0;
    if (wcnt_d != '0) begin
      w_head_d = (w_push && (wrptr_d == wwptr_q)) ? ctrl_data_rx : wmem_q[wrptr_d];
    end
    r_head_d = '0;
    if (rcnt_d != '0) begin
      r_head_d = (r_push && (rrptr_d == rwptr_q)) ? prdata : rmem_q[rrptr_d];
    end

    pending_d = ~cs & (mode_d ? (active_d & (rcnt_d < DepthC)) : (wcnt_d != '0));

    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_d) begin
          state_d = StSetup;
          start   = 1'b1;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready) begin
          if (pending_d) begin
            state_d = StSetup;
            start   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    xfer_valid_d = xfer_valid_q;
    if (flush) xfer_valid_d = 1'b0;
    if (start) xfer_valid_d = 1'b1;

    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    if (start) begin
      paddr_d  = base_d + ADDR_WIDTH'(32'(idx_d) * Step);
      pwrite_d = ~mode_d;
      pwdata_d = mode_d ? '0 : w_head_d;
    end
    psel_d    = (state_d != StIdle);
    penable_d = (state_d == StAccess);
    tx_d      = r_head_d;

    err_d = err_q;
    if (cs && !cs_q) begin
      err_d = '0;
    end else begin
      if (done && pslverr) err_d[0] = 1'b1;
      if (w_ovf)           err_d[1] = 1'b1;
      if (r_udr)           err_d[2] = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= StIdle;
      base_q       <= '0;
      idx_q        <= '0;
      mode_q       <= 1'b0;
      active_q     <= 1'b0;
      xfer_valid_q <= 1'b0;
      cs_q         <= 1'b0;
      wwptr_q      <= '0;
      wrptr_q      <= '0;
      wcnt_q       <= '0;
      rwptr_q      <= '0;
      rrptr_q      <= '0;
      rcnt_q       <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      tx_q         <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      active_q     <= active_d;
      xfer_valid_q <= xfer_valid_d;
      cs_q         <= cs;
      wwptr_q      <= wwptr_d;
      wrptr_q      <= wrptr_d;
      wcnt_q       <= wcnt_d;
      rwptr_q      <= rwptr_d;
      rrptr_q      <= rrptr_d;
      rcnt_q       <= rcnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      tx_q         <= tx_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (w_push) wmem_q[wwptr_q] <= ctrl_data_rx;
    if (r_push) rmem_q[rwptr_q] <= prdata;
  end

  assign psel         = psel_q;
  assign penable      = penable_q;
  assign pwrite       = pwrite_q;
  assign paddr        = paddr_q;
  assign pwdata       = pwdata_q;
  assign ctrl_data_tx = tx_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_spi_slave_apb_sequencer.sv
// Directed bench for spi_slave_apb_sequencer: read prefetch, wrap, backpressure,
// underrun, abort and slave-error scenarios.
module tb_spi_slave_apb_sequencer;

  logic        sclk, sys_rstn, cs;
  logic        ctrl_rd_wr, ctrl_addr_valid, ctrl_data_rx_valid, ctrl_data_tx_ready;
  logic [11:0] ctrl_addr;
  logic [7:0]  ctrl_data_rx, ctrl_data_tx;
  logic [15:0] wrap_length;
  logic [11:0] paddr;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  pwdata, prdata;
  logic [2:0]  err_flags;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] mon_addr[$];
  logic [7:0]  mon_data[$];
  logic        mon_wr[$];

  spi_slave_apb_sequencer #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(2)
  ) dut (
    .sclk               (sclk),
    .sys_rstn           (sys_rstn),
    .cs                 (cs),
    .ctrl_rd_wr         (ctrl_rd_wr),
    .ctrl_addr          (ctrl_addr),
    .ctrl_addr_valid    (ctrl_addr_valid),
    .ctrl_data_rx       (ctrl_data_rx),
    .ctrl_data_rx_valid (ctrl_data_rx_valid),
    .ctrl_data_tx       (ctrl_data_tx),
    .ctrl_data_tx_ready (ctrl_data_tx_ready),
    .wrap_length        (wrap_length),
    .paddr              (paddr),
    .psel               (psel),
    .penable            (penable),
    .pwrite             (pwrite),
    .pwdata             (pwdata),
    .prdata             (prdata),
    .pready             (pready),
    .pslverr            (pslverr),
    .err_flags          (err_flags)
  );

  // Slave read data is a fixed function of the address.
  assign prdata = paddr[7:0] + 8'h30;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (sys_rstn && psel && penable && pready) begin
      mon_addr.push_back(paddr);
      mon_data.push_back(pwrite ? pwdata : prdata);
      mon_wr.push_back(pwrite);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rstn = 1'b0;
    cs = 1'b1;
    ctrl_rd_wr = 1'b0;
    ctrl_addr = '0;
    ctrl_addr_valid = 1'b0;
    ctrl_data_rx = '0;
    ctrl_data_rx_valid = 1'b0;
    ctrl_data_tx_ready = 1'b0;
    wrap_length = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_tx", 32'(ctrl_data_tx), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    sys_rstn = 1'b1;
    tick();
    cs = 1'b0;
    pready = 1'b1;
    tick();

    // Read burst with prefetch, pready tied high
    ctrl_addr = 12'h100; ctrl_rd_wr = 1'b1; ctrl_addr_valid = 1'b1;
    tick();
    ctrl_addr_valid = 1'b0;
    chk("rd_setup_psel", 32'(psel), 32'd1);
    chk("rd_setup_penable", 32'(penable), 32'd0);
    chk("rd_setup_paddr", 32'(paddr), 32'h100);
    chk("rd_setup_pwrite", 32'(pwrite), 32'd0);
    tick();
    chk("rd_access_penable", 32'(penable), 32'd1);
    tick();
    chk("rd_first_tx", 32'(ctrl_data_tx), 32'h30);
    chk("rd_second_paddr", 32'(paddr), 32'h101);
    tick();
    tick();
    chk("rd_prefetch_idle", 32'(psel), 32'd0);
    for (int k = 0; k < 3; k++) begin
      ctrl_data_tx_ready = 1'b1;
      tick();
      ctrl_data_tx_ready = 1'b0;
      repeat (4) tick();
      chk("rd_pop_tx", 32'(ctrl_data_tx), 32'h31 + 32'(k));
    end
    chk("rd_xfer_count", 32'(mon_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rd_paddr_seq", 32'(mon_addr[i]), 32'h100 + 32'(i));
      chk("rd_data_seq", 32'(mon_data[i]), 32'h30 + 32'(i));
      chk("rd_pwrite_seq", 32'(mon_wr[i]), 32'd0);
    end
    cs = 1'b1;
    tick();
    tick();
    cs = 1'b0;
    tick();
    chk("rd_cs_flush_tx", 32'(ctrl_data_tx), 32'd0);
    mon_addr.delete(); mon_data.delete(); mon_wr.delete();

    // Write burst with a 3-word wrap window
    wrap_length = 16'd3;
    ctrl_addr = 12'h040; ctrl_rd_wr = 1'b0; ctrl_addr_valid = 1'b1;
    tick();
    ctrl_addr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ctrl_data_rx = 8'((k + 1) * 17);
      ctrl_data_rx_valid = 1'b1;
      tick();
      ctrl_data_rx_valid = 1'b0;
      if (k == 0) begin
        chk("wr_setup_psel", 32'(psel), 32'd1);
        chk("wr_setup_paddr", 32'(paddr), 32'h040);
        chk("wr_setup_pwdata", 32'(pwdata), 32'h11);
        chk("wr_setup_pwrite", 32'(pwrite), 32'd1);
      end
      tick();
      tick();
    end
    repeat (3) tick();
    chk("wrap_xfer_count", 32'(mon_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("wrap_paddr_seq", 32'(mon_addr[i]), 32'h040 + 32'(i % 3));
      chk("wrap_data_seq", 32'(mon_data[i]), 32'((i + 1) * 17));
      chk("wrap_pwrite_seq", 32'(mon_wr[i]), 32'd1);
    end
    chk("wrap_err", 32'(err_flags), 32'd0);
    mon_addr.delete(); mon_data.delete(); mon_wr.delete();
    wrap_length = 16'd0;

    // Backpressure: third write overflows the 2-deep FIFO
    pready = 1'b0;
    ctrl_addr = 12'h200; ctrl_addr_valid = 1'b1;
    tick();
    ctrl_addr_valid = 1'b0;
    ctrl_data_rx = 8'hA1; ctrl_data_rx_valid = 1'b1;
    tick();
    ctrl_data_rx = 8'hA2;
    tick();
    ctrl_data_rx = 8'hA3;
    tick();
    ctrl_data_rx_valid = 1'b0;
    chk("bp_err_ovf", 32'(err_flags), 32'b010);
    chk("bp_held_psel", 32'(psel), 32'd1);
    chk("bp_held_penable", 32'(penable), 32'd1);
    tick();
    tick();
    tick();
    pready = 1'b1;
    repeat (6) tick();
    chk("bp_xfer_count", 32'(mon_addr.size()), 32'd2);
    chk("bp_addr0", 32'(mon_addr[0]), 32'h200);
    chk("bp_data0", 32'(mon_data[0]), 32'hA1);
    chk("bp_addr1", 32'(mon_addr[1]), 32'h201);
    chk("bp_data1", 32'(mon_data[1]), 32'hA2);
    mon_addr.delete(); mon_data.delete(); mon_wr.delete();

    // Underrun, then cs clears the sticky flags
    ctrl_data_tx_ready = 1'b1;
    tick();
    ctrl_data_tx_ready = 1'b0;
    chk("udr_tx", 32'(ctrl_data_tx), 32'd0);
    chk("udr_err", 32'(err_flags), 32'b110);
    cs = 1'b1;
    tick();
    chk("cs_clear_err", 32'(err_flags), 32'd0);
    cs = 1'b0;
    tick();

    // Abort: cs rises during ACCESS of a read
    pready = 1'b0;
    ctrl_addr = 12'h300; ctrl_rd_wr = 1'b1; ctrl_addr_valid = 1'b1;
    tick();
    ctrl_addr_valid = 1'b0;
    chk("ab_setup_paddr", 32'(paddr), 32'h300);
    tick();
    chk("ab_access_penable", 32'(penable), 32'd1);
    cs = 1'b1;
    tick();
    chk("ab_held_psel", 32'(psel), 32'd1);
    chk("ab_held_penable", 32'(penable), 32'd1);
    pready = 1'b1;
    tick();
    chk("ab_done_psel", 32'(psel), 32'd0);
    cs = 1'b0;
    repeat (4) tick();
    chk("ab_no_setup", 32'(psel), 32'd0);
    chk("ab_discard_tx", 32'(ctrl_data_tx), 32'd0);
    chk("ab_xfer_count", 32'(mon_addr.size()), 32'd1);
    mon_addr.delete(); mon_data.delete(); mon_wr.delete();

    // Slave error on a write; burst continues at the next address
    ctrl_addr = 12'h050; ctrl_rd_wr = 1'b0; ctrl_addr_valid = 1'b1;
    tick();
    ctrl_addr_valid = 1'b0;
    ctrl_data_rx = 8'h77; ctrl_data_rx_valid = 1'b1;
    tick();
    ctrl_data_rx_valid = 1'b0;
    tick();
    pslverr = 1'b1;
    tick();
    pslverr = 1'b0;
    chk("slverr_flag", 32'(err_flags), 32'b001);
    ctrl_data_rx = 8'h88; ctrl_data_rx_valid = 1'b1;
    tick();
    ctrl_data_rx_valid = 1'b0;
    chk("slverr_next_psel", 32'(psel), 32'd1);
    chk("slverr_next_paddr", 32'(paddr), 32'h051);
    chk("slverr_next_pwdata", 32'(pwdata), 32'h88);
    tick();
    tick();
    chk("slverr_xfer_count", 32'(mon_addr.size()), 32'd2);
    chk("slverr_addr0", 32'(mon_addr[0]), 32'h050);
    chk("slverr_data0", 32'(mon_data[0]), 32'h77);
    chk("slverr_sticky", 32'(err_flags), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
